// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: 64x32 program store loaded over ld_*, fetched by pc.
// Optional fetch counter port/logic under `define IFU_FETCH_CNT_EN.
module inst_fetch_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_valid,
   input  logic [5:0]  ld_addr,
   input  logic [31:0] ld_data,
   output logic        ld_ready,
   input  logic        start,
   input  logic [31:0] pc,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic        halted,
   output logic        addr_err
`ifdef IFU_FETCH_CNT_EN
   ,
   output logic [15:0] fetch_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] mem_q [64];
   logic [31:0] inst_q, inst_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic        halt_seen;
   logic        fetch_en;
   logic        pc_bad;

   // halt word is on the outputs this cycle; no further fetch is issued
   assign halt_seen = valid_q && (inst_q[31:26] == 6'h3F);
   assign pc_bad    = (|pc[1:0]) || (|pc[31:8]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start)         state_d = RUN;
            else if (ld_valid) state_d = LOAD;
         end
         LOAD: begin
            if (start)          state_d = RUN;
            else if (!ld_valid) state_d = IDLE;
         end
         RUN:     if (halt_seen) state_d = HALT;
         HALT:    if (start)     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ld_ready = (state_q == IDLE) || (state_q == LOAD);
      halted   = (state_q == HALT);
      fetch_en = (state_q == RUN) && !halt_seen;
   end

   always_ff @(posedge clk) begin
      if (ld_valid && ld_ready) mem_q[ld_addr] <= ld_data;
   end

   always_comb begin
      inst_d  = '0;
      valid_d = 1'b0;
      err_d   = err_q;
      if (fetch_en) begin
         valid_d = 1'b1;
         if (pc_bad) err_d  = 1'b1;
         else        inst_d = mem_q[pc[7:2]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         inst_q  <= inst_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign inst       = inst_q;
   assign inst_valid = valid_q;
   assign addr_err   = err_q;

`ifdef IFU_FETCH_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start && (state_q != RUN))
         cnt_d = '0;
      else if (valid_q && (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign fetch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit.
// Inputs change and outputs are checked on the falling clock edge.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_valid;
   logic [5:0]  ld_addr;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        start;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        inst_valid;
   logic        halted;
   logic        addr_err;
`ifdef IFU_FETCH_CNT_EN
   logic [15:0] fetch_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inst_fetch_unit dut (
      .clk        (clk),
      .rst        (rst),
      .ld_valid   (ld_valid),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .start      (start),
      .pc         (pc),
      .inst       (inst),
      .inst_valid (inst_valid),
      .halted     (halted),
      .addr_err   (addr_err)
`ifdef IFU_FETCH_CNT_EN
      ,
      .fetch_cnt  (fetch_cnt)
`endif
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic load_word(input logic [5:0] a, input logic [31:0] d);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
      step();
      ld_valid = 1'b0;
      step();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_rst();
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      checks++;
      if (inst !== 32'h0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_inst got %h/%b exp 0/0", inst, inst_valid);
      end
      checks++;
      if (halted !== 1'b0 || addr_err !== 1'b0 || ld_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_flags got h%b e%b r%b exp h0 e0 r1",
                  halted, addr_err, ld_ready);
      end
`ifdef IFU_FETCH_CNT_EN
      checks++;
      if (fetch_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt got %0d exp 0", fetch_cnt);
      end
`endif
      rst = 1'b0;
      step();
      checks++;
      if (inst_valid !== 1'b0 || ld_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset got v%b r%b exp v0 r1", inst_valid, ld_ready);
      end
   endtask

   task automatic test_basic();
      load_word(6'd0, 32'h0042_1006);
      pulse_start();
      pc = 32'h0;
      step();
      checks++;
      if (inst !== 32'h0042_1006 || inst_valid !== 1'b1) begin
         errors++;
         $display("FAIL basic_fetch got %h/%b exp 00421006/1", inst, inst_valid);
      end
      pulse_rst();
   endtask

   task automatic test_halt();
      logic [31:0] exp_w [3];
      exp_w[0] = 32'h1111_1111;
      exp_w[1] = 32'h2222_2222;
      exp_w[2] = 32'hFC00_0000;
      for (int i = 0; i < 3; i++) load_word(6'(i), exp_w[i]);
      load_word(6'd63, 32'h3C3C_3C3C);
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         pc = 32'(i * 4);
         step();
         checks++;
         if (inst !== exp_w[i] || inst_valid !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_seq%0d got %h/%b h%b exp %h/1 h0",
                     i, inst, inst_valid, halted, exp_w[i]);
         end
      end
      pc = 32'hC;
      step();
      checks++;
      if (halted !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'h0) begin
         errors++;
         $display("FAIL halt_state got h%b v%b i%h exp h1 v0 i0",
                  halted, inst_valid, inst);
      end
      step();
`ifdef IFU_FETCH_CNT_EN
      checks++;
      if (fetch_cnt !== 16'd3) begin
         errors++;
         $display("FAIL halt_cnt got %0d exp 3", fetch_cnt);
      end
`endif
      pulse_start();
      checks++;
      if (ld_ready !== 1'b1 || halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_exit got r%b h%b exp r1 h0", ld_ready, halted);
      end
`ifdef IFU_FETCH_CNT_EN
      checks++;
      if (fetch_cnt !== 16'd0) begin
         errors++;
         $display("FAIL cnt_clear got %0d exp 0", fetch_cnt);
      end
`endif
   endtask

   task automatic test_addr_err();
      pulse_rst();
      pulse_start();
      pc = 32'hFC;
      step();
      checks++;
      if (inst !== 32'h3C3C_3C3C || inst_valid !== 1'b1 || addr_err !== 1'b0) begin
         errors++;
         $display("FAIL pc_fc got %h/%b e%b exp 3c3c3c3c/1 e0",
                  inst, inst_valid, addr_err);
      end
      pc = 32'h100;
      step();
      checks++;
      if (inst !== 32'h0 || inst_valid !== 1'b1 || addr_err !== 1'b1) begin
         errors++;
         $display("FAIL pc_100 got %h/%b e%b exp 0/1 e1",
                  inst, inst_valid, addr_err);
      end
      pc    = 32'h4;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (inst !== 32'h2222_2222 || inst_valid !== 1'b1 || addr_err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky got %h/%b e%b exp 22222222/1 e1",
                  inst, inst_valid, addr_err);
      end
      pc = 32'h2;
      step();
      checks++;
      if (inst !== 32'h0 || inst_valid !== 1'b1 || halted !== 1'b0) begin
         errors++;
         $display("FAIL pc_2 got %h/%b h%b exp 0/1 h0", inst, inst_valid, halted);
      end
      pc = 32'h8000_0000;
      step();
      checks++;
      if (inst !== 32'h0 || inst_valid !== 1'b1 || addr_err !== 1'b1) begin
         errors++;
         $display("FAIL pc_hi got %h/%b e%b exp 0/1 e1", inst, inst_valid, addr_err);
      end
      pc = 32'h8;
      step();
      step();
      checks++;
      if (halted !== 1'b1 || addr_err !== 1'b1) begin
         errors++;
         $display("FAIL err_halt got h%b e%b exp h1 e1", halted, addr_err);
      end
      pulse_start();
   endtask

   task automatic test_reset_mid_run();
      load_word(6'd0, 32'h0042_1006);
      pulse_start();
      pc = 32'h0;
      step();
      step();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (inst !== 32'h0 || inst_valid !== 1'b0 || halted !== 1'b0 ||
          addr_err !== 1'b0 || ld_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_rst got %h v%b h%b e%b r%b exp 0 v0 h0 e0 r1",
                  inst, inst_valid, halted, addr_err, ld_ready);
      end
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_release%0d got v%b exp v0", i, inst_valid);
         end
      end
      pulse_start();
      step();
      checks++;
      if (inst !== 32'h0042_1006 || inst_valid !== 1'b1) begin
         errors++;
         $display("FAIL refetch got %h/%b exp 00421006/1", inst, inst_valid);
      end
      pulse_rst();
   endtask

   task automatic test_load_blocked();
      load_word(6'd5, 32'h55AA_55AA);
      pulse_start();
      ld_valid = 1'b1;
      ld_addr  = 6'd5;
      ld_data  = 32'hDEAD_BEEF;
      pc       = 32'h0;
      step();
      checks++;
      if (ld_ready !== 1'b0) begin
         errors++;
         $display("FAIL run_ready got %b exp 0", ld_ready);
      end
      pc = 32'h8;
      step();
      step();
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL blk_halt got %b exp 1", halted);
      end
      step();
      ld_valid = 1'b0;
      step();
      pulse_start();
      load_word(6'd3, 32'h3333_3333);
      pulse_start();
      pc = 32'h14;
      step();
      checks++;
      if (inst !== 32'h55AA_55AA || inst_valid !== 1'b1) begin
         errors++;
         $display("FAIL word5 got %h/%b exp 55aa55aa/1", inst, inst_valid);
      end
      pc = 32'hC;
      step();
      checks++;
      if (inst !== 32'h3333_3333 || inst_valid !== 1'b1) begin
         errors++;
         $display("FAIL word3 got %h/%b exp 33333333/1", inst, inst_valid);
      end
      pulse_rst();
   endtask

   initial begin
      rst      = 1'b1;
      ld_valid = 1'b0;
      ld_addr  = '0;
      ld_data  = '0;
      start    = 1'b0;
      pc       = '0;
      step();
      step();
      test_reset();
      test_basic();
      test_halt();
      test_addr_err();
      test_reset_mid_run();
      test_load_blocked();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
